// File: rtl/escalonador_pkg.sv
// -----------------------------------------------------------------------------
// escalonador_pkg
// Shared definitions for the reservation-station scheduler escalonador_uf:
//   - default widths and entry count
//   - functional-unit opcode constants (opcode = instr[15:12])
//   - FSM state enumeration
//   - reservation entry record
//   - saturating age increment helper (used when PRIORIDADE_IDADE_EN is defined)
// -----------------------------------------------------------------------------
package escalonador_pkg;

   localparam int ESC_N_ENTRIES = 4;
   localparam int ESC_DATA_W    = 16;
   localparam int ESC_INSTR_W   = 16;
   localparam int ESC_TAG_W     = 8;
   localparam int ESC_AGE_W     = 3;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_SD  = 4'b0010;
   localparam logic [3:0] OP_LD  = 4'b0011;

   typedef enum logic [1:0] {
      LIVRE    = 2'd0,
      DESPACHO = 2'd1,
      ESPERA   = 2'd2
   } estado_t;

   typedef struct packed {
      logic                   valid;
      logic [ESC_INSTR_W-1:0] instr;
      logic [ESC_TAG_W-1:0]   num;
      logic [ESC_DATA_W-1:0]  v1;
      logic [ESC_DATA_W-1:0]  v2;
      logic                   pend1;
      logic [ESC_TAG_W-1:0]   q1;
      logic                   pend2;
      logic [ESC_TAG_W-1:0]   q2;
      logic [ESC_AGE_W-1:0]   age;
   } entrada_t;

   // Saturating increment: an entry that has seen 7+ younger issues stays at 7.
   function automatic logic [ESC_AGE_W-1:0] idade_inc(input logic [ESC_AGE_W-1:0] a);
      logic [ESC_AGE_W-1:0] r;
      r = (a == 3'd7) ? a : (a + 3'd1);
      return r;
   endfunction

endpackage

// File: rtl/escalonador_uf_seletor_pronto.sv
// -----------------------------------------------------------------------------
// seletor_pronto
// Purely combinational selection of the entry to dispatch.
//   valid, pend1, pend2 : per-entry state flags (bit i = entry i)
//   ages                : per-entry 3-bit ages, only present with PRIORIDADE_IDADE_EN
//   idx                 : selected entry index
//   found               : at least one entry is ready
// Ready = valid && !pend1 && !pend2.
// Default build: lowest-index ready entry wins.
// With macro PRIORIDADE_IDADE_EN: the oldest ready entry wins, ties go to the
// lowest index.
// -----------------------------------------------------------------------------
module seletor_pronto
   import escalonador_pkg::*;
#(
   parameter int N_ENTRIES = ESC_N_ENTRIES,
   parameter int IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
   input  logic [N_ENTRIES-1:0]           valid,
   input  logic [N_ENTRIES-1:0]           pend1,
   input  logic [N_ENTRIES-1:0]           pend2,
`ifdef PRIORIDADE_IDADE_EN
   input  logic [N_ENTRIES*ESC_AGE_W-1:0] ages,
`endif
   output logic [IDX_W-1:0]               idx,
   output logic                           found
);

   logic [N_ENTRIES-1:0] ready;

   // Ready mask and priority scan; a later entry only takes over when it is
   // strictly better, so ties stay with the lower index.
   always_comb begin
      logic                 take;
`ifdef PRIORIDADE_IDADE_EN
      logic [ESC_AGE_W-1:0] best_age;
      best_age = 3'd0;
`endif
      ready = valid & ~pend1 & ~pend2;
      idx   = '0;
      found = 1'b0;
      take  = 1'b0;
      for (int i = 0; i < N_ENTRIES; i++) begin
`ifdef PRIORIDADE_IDADE_EN
         take     = ready[i] && (!found || (ages[i*ESC_AGE_W +: ESC_AGE_W] > best_age));
         best_age = take ? ages[i*ESC_AGE_W +: ESC_AGE_W] : best_age;
`else
         take     = ready[i] && !found;
`endif
         idx   = take ? IDX_W'(i) : idx;
         found = found | take;
      end
   end

endmodule

// File: rtl/escalonador_uf.sv
// -----------------------------------------------------------------------------
// escalonador_uf
// Reservation-station scheduler in front of one functional unit (FU).
// Holds issued instructions until both operands are known (snooping the CDB),
// then dispatches one entry at a time using the FU enable/available/done
// handshake. Only one instruction is outstanding in the FU at any time.
//
// Ports:
//   clock, reset                 : posedge clock, asynchronous active-high reset
//   issue_valid / issue_ready    : issue handshake (ready while an entry is free)
//   issue_instr, issue_num       : instruction word and its result tag
//   issue_v1/v2, issue_q1/q2,
//   issue_q1_pend/q2_pend        : operand values or producer tags
//   cdb_valid, cdb_tag, cdb_data : common data bus broadcast
//   uf_disponivel, uf_done       : FU available flag and completion pulse
//   disp_en                      : one-cycle dispatch pulse (FU instrEn)
//   disp_instr/num/r1/r2         : dispatched instruction, held until next dispatch
//   ocupacao                     : number of valid entries
//
// Configuration macro: PRIORIDADE_IDADE_EN (age-based selection of the oldest
// ready entry; undefined = strict lowest-index ready entry).
// -----------------------------------------------------------------------------
module escalonador_uf
   import escalonador_pkg::*;
#(
   parameter int N_ENTRIES = ESC_N_ENTRIES,
   parameter int DATA_W    = ESC_DATA_W,
   parameter int INSTR_W   = ESC_INSTR_W,
   parameter int TAG_W     = ESC_TAG_W
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           issue_valid,
   output logic                           issue_ready,
   input  logic [INSTR_W-1:0]             issue_instr,
   input  logic [TAG_W-1:0]               issue_num,
   input  logic [DATA_W-1:0]              issue_v1,
   input  logic [DATA_W-1:0]              issue_v2,
   input  logic                           issue_q1_pend,
   input  logic                           issue_q2_pend,
   input  logic [TAG_W-1:0]               issue_q1,
   input  logic [TAG_W-1:0]               issue_q2,
   input  logic                           cdb_valid,
   input  logic [TAG_W-1:0]               cdb_tag,
   input  logic [DATA_W-1:0]              cdb_data,
   input  logic                           uf_disponivel,
   input  logic                           uf_done,
   output logic                           disp_en,
   output logic [INSTR_W-1:0]             disp_instr,
   output logic [TAG_W-1:0]               disp_num,
   output logic [DATA_W-1:0]              disp_r1,
   output logic [DATA_W-1:0]              disp_r2,
   output logic [$clog2(N_ENTRIES+1)-1:0] ocupacao
);

   localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
   localparam int OCC_W = $clog2(N_ENTRIES + 1);

   entrada_t             ent      [N_ENTRIES];
   entrada_t             ent_next [N_ENTRIES];
   entrada_t             nova;
   estado_t              estado;
   estado_t              estado_next;
   logic [N_ENTRIES-1:0] valid_vec;
   logic [N_ENTRIES-1:0] pend1_vec;
   logic [N_ENTRIES-1:0] pend2_vec;
   logic [IDX_W-1:0]     sel_idx;
   logic                 sel_found;
   logic [IDX_W-1:0]     free_idx;
   logic                 accept;
   logic                 dispatch;
   logic [OCC_W-1:0]     ocupacao_next;
`ifdef PRIORIDADE_IDADE_EN
   logic [N_ENTRIES*ESC_AGE_W-1:0] ages_vec;
`endif

   // A free entry always exists while ocupacao is below capacity, so
   // free_idx is meaningful whenever issue_ready is high.
   assign issue_ready = (ocupacao != OCC_W'(N_ENTRIES));
   assign accept      = issue_valid && issue_ready;

   // Flatten registered entry flags for the selector and find the lowest free slot.
   always_comb begin
      logic got_free;
      got_free = 1'b0;
      free_idx = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         valid_vec[i] = ent[i].valid;
         pend1_vec[i] = ent[i].pend1;
         pend2_vec[i] = ent[i].pend2;
`ifdef PRIORIDADE_IDADE_EN
         ages_vec[i*ESC_AGE_W +: ESC_AGE_W] = ent[i].age;
`endif
         free_idx = (!ent[i].valid && !got_free) ? IDX_W'(i) : free_idx;
         got_free = got_free | !ent[i].valid;
      end
   end

   seletor_pronto #(
      .N_ENTRIES (N_ENTRIES),
      .IDX_W     (IDX_W)
   ) u_seletor (
      .valid (valid_vec),
      .pend1 (pend1_vec),
      .pend2 (pend2_vec),
`ifdef PRIORIDADE_IDADE_EN
      .ages  (ages_vec),
`endif
      .idx   (sel_idx),
      .found (sel_found)
   );

   // Build the incoming entry, forwarding a same-cycle CDB value into a pending operand.
   always_comb begin
      nova       = '0;
      nova.valid = 1'b1;
      nova.instr = issue_instr;
      nova.num   = issue_num;
      nova.q1    = issue_q1;
      nova.q2    = issue_q2;
      nova.age   = 3'd0;
      if (issue_q1_pend && cdb_valid && (issue_q1 == cdb_tag)) begin
         nova.v1    = cdb_data;
         nova.pend1 = 1'b0;
      end else begin
         nova.v1    = issue_v1;
         nova.pend1 = issue_q1_pend;
      end
      if (issue_q2_pend && cdb_valid && (issue_q2 == cdb_tag)) begin
         nova.v2    = cdb_data;
         nova.pend2 = 1'b0;
      end else begin
         nova.v2    = issue_v2;
         nova.pend2 = issue_q2_pend;
      end
   end

   // FSM next state; a dispatch only fires from LIVRE with a ready entry and an available FU.
   always_comb begin
      estado_next = estado;
      dispatch    = 1'b0;
      case (estado)
         LIVRE: begin
            if (sel_found && uf_disponivel) begin
               dispatch    = 1'b1;
               estado_next = DESPACHO;
            end else begin
               estado_next = LIVRE;
            end
         end
         // The FU samples instrEn on this edge; uf_done is not meaningful yet.
         DESPACHO: estado_next = ESPERA;
         ESPERA: begin
            if (uf_done) begin
               estado_next = LIVRE;
            end else begin
               estado_next = ESPERA;
            end
         end
         default: estado_next = LIVRE;
      endcase
   end

   // Per-entry next state: CDB capture, ageing, dispatch release and issue write.
   // The dispatched entry is valid and the issue target is invalid, so the two
   // never land on the same entry within one edge.
   always_comb begin
      for (int i = 0; i < N_ENTRIES; i++) begin
         ent_next[i] = ent[i];
         if (ent[i].valid && ent[i].pend1 && cdb_valid && (ent[i].q1 == cdb_tag)) begin
            ent_next[i].v1    = cdb_data;
            ent_next[i].pend1 = 1'b0;
         end else begin
            ent_next[i].pend1 = ent[i].pend1;
         end
         if (ent[i].valid && ent[i].pend2 && cdb_valid && (ent[i].q2 == cdb_tag)) begin
            ent_next[i].v2    = cdb_data;
            ent_next[i].pend2 = 1'b0;
         end else begin
            ent_next[i].pend2 = ent[i].pend2;
         end
`ifdef PRIORIDADE_IDADE_EN
         if (accept && ent[i].valid) begin
            ent_next[i].age = idade_inc(ent[i].age);
         end else begin
            ent_next[i].age = ent[i].age;
         end
`else
         ent_next[i].age = 3'd0;
`endif
         if (dispatch && (sel_idx == IDX_W'(i))) begin
            ent_next[i].valid = 1'b0;
         end else if (accept && (free_idx == IDX_W'(i))) begin
            ent_next[i] = nova;
         end else begin
            ent_next[i].valid = ent[i].valid;
         end
      end
   end

   // Occupancy tracks issues in and dispatches out; both on one edge cancel.
   always_comb begin
      case ({accept, dispatch})
         2'b10:   ocupacao_next = ocupacao + OCC_W'(1);
         2'b01:   ocupacao_next = ocupacao - OCC_W'(1);
         default: ocupacao_next = ocupacao;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= LIVRE;
      end else begin
         estado <= estado_next;
      end
   end

   // Reservation entries and occupancy count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_ENTRIES; i++) begin
            ent[i] <= '0;
         end
         ocupacao <= '0;
      end else begin
         for (int i = 0; i < N_ENTRIES; i++) begin
            ent[i] <= ent_next[i];
         end
         ocupacao <= ocupacao_next;
      end
   end

   // Dispatch outputs: pulse on the dispatch edge, payload held until the next
   // dispatch because the FU re-reads instr while it is busy.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         disp_en    <= 1'b0;
         disp_instr <= '0;
         disp_num   <= '0;
         disp_r1    <= '0;
         disp_r2    <= '0;
      end else begin
         disp_en <= dispatch;
         if (dispatch) begin
            disp_instr <= ent[sel_idx].instr;
            disp_num   <= ent[sel_idx].num;
            disp_r1    <= ent[sel_idx].v1;
            disp_r2    <= ent[sel_idx].v2;
         end else begin
            disp_instr <= disp_instr;
            disp_num   <= disp_num;
            disp_r1    <= disp_r1;
            disp_r2    <= disp_r2;
         end
      end
   end

endmodule

// File: doc/escalonador_uf.md
Name: escalonador_uf

Overview:
- Reservation-station scheduler placed in front of one functional unit (ADD/SUB/SD/LD, 16-bit instructions).
- Buffers issued instructions whose operands may still be pending on producer tags, and snoops the common data bus (CDB) for those values.
- Dispatches one ready entry at a time to the FU using its enable/available/done handshake.
- Only one instruction is ever outstanding in the FU.

Parameters:
- N_ENTRIES, 4, number of reservation entries (2..8)
- DATA_W, 16, operand/result width
- INSTR_W, 16, instruction width
- TAG_W, 8, instruction-number/tag width (also the CDB tag)

Ports:
- clock  in  1  single system clock, posedge
- reset  in  1  asynchronous, active-high; clears all state
- issue_valid  in  1  new instruction offered
- issue_ready  out  1  a free entry exists (registered-state derived)
- issue_instr  in  INSTR_W  instruction word
- issue_num  in  TAG_W  instruction number (its result tag)
- issue_v1, issue_v2  in  DATA_W  operand values, valid when matching q*_pend=0
- issue_q1_pend, issue_q2_pend  in  1  operand awaits a producer
- issue_q1, issue_q2  in  TAG_W  producer tags
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  producing instruction number
- cdb_data  in  DATA_W  broadcast value
- uf_disponivel  in  1  FU available flag
- uf_done  in  1  FU completion pulse
- disp_en  out  1  one-cycle dispatch pulse to FU instrEn
- disp_instr  out  INSTR_W  to FU instr
- disp_num  out  TAG_W  to FU instrNumIn
- disp_r1, disp_r2  out  DATA_W  to FU r1/r2
- ocupacao  out  clog2(N_ENTRIES+1)  valid-entry count

Behaviour:
- Reset (async): all entries invalid; state=LIVRE; disp_en=0; disp_instr/disp_num/disp_r1/disp_r2=0; ocupacao=0; issue_ready=1.
- issue_ready = (ocupacao != N_ENTRIES).
- Issue accepted on a posedge when issue_valid && issue_ready. The instruction is written into the lowest-index free entry. issue_valid is ignored when full.
- Operand capture from the CDB:
  - Every posedge with cdb_valid, each valid entry whose operand is pending with q==cdb_tag captures cdb_data and clears pend.
  - Same-cycle forwarding: if an accepted issue operand is pending with q==cdb_tag while cdb_valid, it is stored as ready with cdb_data.
  - Both operands of one entry may capture on the same edge.
- Entry ready = valid && !pend1 && !pend2, evaluated on registered state. A value captured on edge k makes the entry eligible from edge k+1.
- FSM states: LIVRE, DESPACHO, ESPERA.
  - LIVRE: if any entry is ready && uf_disponivel, on the posedge: load the selected entry into the disp_* outputs, set disp_en=1, free the entry (ocupacao decrements, nets with a simultaneous issue), and go to DESPACHO.
  - DESPACHO: disp_en=0; uf_done is ignored; go to ESPERA. This covers the edge at which the FU samples.
  - ESPERA: on uf_done=1, go to LIVRE. The next dispatch can occur at the earliest on the following edge.
- disp_instr/disp_num/disp_r1/disp_r2 hold their values from the dispatch edge until the next dispatch. The FU re-reads instr every cycle, so these must not change while it is busy.
- Latency: entry ready at edge k → disp_en high after edge k → FU samples at k+1. LD/SD return to LIVRE at k+2; ADD/SUB at k+4.
- Selection: lowest-index ready entry (see Optional Feature).
- Reset mid-operation (DESPACHO/ESPERA): returns to LIVRE and drops all entries. The FU is not reset by this block; system reset covers both.
- An issue, a CDB capture and a dispatch may all occur on one edge. A freed entry is reusable on the next edge, not the same one.

Optional Feature:
- Macro PRIORIDADE_IDADE_EN.
- Defined: each entry holds a 3-bit age, set to 0 on issue. Ages of other valid entries saturate-increment on every accepted issue. Among ready entries, the oldest is selected; ties go to the lowest index.
- Undefined: no age storage; strict lowest-index ready entry.

Decomposition:
- Package escalonador_pkg:
  - opcode constants ADD=4'b0000, SUB=4'b0001, SD=4'b0010, LD=4'b0011
  - FSM state enum
  - entry struct {valid, instr, num, v1, v2, pend1, q1, pend2, q2, age}
  - default widths
- Sub-module seletor_pronto: purely combinational ready-mask plus optional-age priority select, outputting the index and a found flag.

Test Plan:
- Issue ADD num=1, v1=3, v2=5, no pend; uf_disponivel=1 → disp_en pulse one cycle after issue with disp_r1=3, disp_r2=5, disp_num=1. No second disp_en until uf_done (3 FU cycles).
- Issue SUB num=2 with q1_pend tag=1, then CDB tag=1 data=7 → entry captures 7 and dispatches the following cycle with disp_r1=7. With the CDB in the same cycle as issue, the same result occurs via forwarding.
- Fill 4 entries all pending → issue_ready=0 and a fifth issue_valid is ignored. The CDB releases entry 2; it dispatches; issue_ready returns to 1 next cycle.
- Entries 0 and 3 ready, entry 3 issued first → lowest-index selects 0. With PRIORIDADE_IDADE_EN, 3 is selected.
- LD dispatch; uf_done arrives one cycle after the FU samples → back to LIVRE. A back-to-back ready SD dispatches on the next edge, and disp_instr holds the LD word until then.
- Assert reset during ESPERA with 3 valid entries → disp_en=0, ocupacao=0, issue_ready=1 immediately (asynchronous).
